// File: rtl/tachyon_pkg.sv
// Shared types and constants for the tachyon memory arbiter.
package tachyon_pkg;

   localparam int unsigned MAX_PORTS = 8;

   typedef logic [$clog2(MAX_PORTS)-1:0] port_id_t;

   localparam int unsigned ERR_SPURIOUS      = 0;
   localparam int unsigned ERR_ADDR_MISMATCH = 1;

   // Next round-robin pointer: one past id, wrapping at n-1.
   function automatic port_id_t wrap_inc(input port_id_t id, input int unsigned n);
      return (32'(id) == n - 1) ? '0 : port_id_t'(id + 1'b1);
   endfunction

endpackage

// File: rtl/tachyon_rr_arbiter.sv
// Round-robin picker: first request at or after ptr_i wins; also returns the pointer to use next.
module tachyon_rr_arbiter
   import tachyon_pkg::*;
#(
   parameter int unsigned NR_PORTS = 2
) (
   input  logic [NR_PORTS-1:0] req_i,
   input  port_id_t            ptr_i,
   output logic [NR_PORTS-1:0] gnt_o,
   output logic                gnt_valid_o,
   output port_id_t            gnt_id_o,
   output port_id_t            next_ptr_o
);

   logic [NR_PORTS-1:0] hi_req;
   logic [NR_PORTS-1:0] sel_req;

   // Requests at or above the pointer take priority; otherwise wrap to the lowest request.
   always_comb begin
      hi_req = '0;
      for (int unsigned i = 0; i < NR_PORTS; i++) begin
         hi_req[i] = req_i[i] && (i >= 32'(ptr_i));
      end
      sel_req = (|hi_req) ? hi_req : req_i;
   end

   always_comb begin
      gnt_valid_o = 1'b0;
      gnt_id_o    = '0;
      gnt_o       = '0;
      for (int unsigned i = 0; i < NR_PORTS; i++) begin
         if (!gnt_valid_o && sel_req[i]) begin
            gnt_valid_o = 1'b1;
            gnt_id_o    = port_id_t'(i);
         end
      end
      for (int unsigned i = 0; i < NR_PORTS; i++) begin
         gnt_o[i] = gnt_valid_o && (gnt_id_o == port_id_t'(i));
      end
      next_ptr_o = gnt_valid_o ? wrap_inc(gnt_id_o, NR_PORTS) : ptr_i;
   end

endmodule

// File: rtl/tachyon_mem_arb.sv
// Multi-port RAM arbiter with in-order read tracking and zero-latency response routing.
// Optional TACHYON_MEM_ARB_ADDR_CHECK_EN: store read addresses and flag return-address mismatches.
module tachyon_mem_arb
   import tachyon_pkg::*;
#(
   parameter int unsigned NR_PORTS        = 2,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NR_PORTS-1:0]              req,
   input  logic [NR_PORTS-1:0]              wr_rd,
   input  logic [NR_PORTS*(ADDR_WIDTH-2)-1:0] addr,
   input  logic [NR_PORTS*DATA_WIDTH-1:0]   wdata,
   output logic [NR_PORTS-1:0]              gnt,
   output logic [NR_PORTS-1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]            rsp_data,
   output logic                             ram_rd_en,
   output logic [ADDR_WIDTH-3:0]            ram_rd_addr,
   output logic                             ram_wr_en,
   output logic [ADDR_WIDTH-3:0]            ram_wr_addr,
   output logic [DATA_WIDTH-1:0]            ram_wr_data,
   input  logic                             ram_rd_valid,
   input  logic [DATA_WIDTH-1:0]            ram_rd_data,
   input  logic [ADDR_WIDTH-3:0]            ram_rd_addr_out,
   output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
   output logic [1:0]                       err
);

   localparam int unsigned AW = ADDR_WIDTH - 2;
   localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CW = PW + 1;

   port_id_t            ptr_q, ptr_d;
   port_id_t            gnt_id, next_ptr;
   logic                gnt_valid;
   logic [NR_PORTS-1:0] elig;
   logic                rd_ok, push, pop, spurious;
   logic                sel_wr;
   logic [AW-1:0]       sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   port_id_t            fifo_id_q [MAX_OUTSTANDING];
   port_id_t            fifo_id_d [MAX_OUTSTANDING];
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [1:0]          err_q, err_d;

`ifdef TACHYON_MEM_ARB_ADDR_CHECK_EN
   logic [AW-1:0]       fifo_addr_q [MAX_OUTSTANDING];
   logic [AW-1:0]       fifo_addr_d [MAX_OUTSTANDING];
`else
   logic                unused_addr_out;
   assign unused_addr_out = ^ram_rd_addr_out;
`endif

   // A same-cycle return frees a slot, so a read may be granted even when full.
   always_comb begin
      rd_ok = (cnt_q < CW'(MAX_OUTSTANDING)) || ram_rd_valid;
      for (int unsigned i = 0; i < NR_PORTS; i++) begin
         elig[i] = rst_n && req[i] && (wr_rd[i] || rd_ok);
      end
   end

   tachyon_rr_arbiter #(
      .NR_PORTS (NR_PORTS)
   ) u_rr_arbiter (
      .req_i       (elig),
      .ptr_i       (ptr_q),
      .gnt_o       (gnt),
      .gnt_valid_o (gnt_valid),
      .gnt_id_o    (gnt_id),
      .next_ptr_o  (next_ptr)
   );

   always_comb begin
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NR_PORTS; i++) begin
         if (gnt_id == port_id_t'(i)) begin
            sel_wr    = wr_rd[i];
            sel_addr  = addr[i*AW +: AW];
            sel_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      push        = gnt_valid && !sel_wr;
      ram_rd_en   = push;
      ram_rd_addr = push ? sel_addr : '0;
      ram_wr_en   = gnt_valid && sel_wr;
      ram_wr_addr = ram_wr_en ? sel_addr : '0;
      ram_wr_data = ram_wr_en ? sel_wdata : '0;
   end

   always_comb begin
      pop       = rst_n && ram_rd_valid && (cnt_q != '0);
      spurious  = rst_n && ram_rd_valid && (cnt_q == '0);
      rsp_data  = pop ? ram_rd_data : '0;
      for (int unsigned i = 0; i < NR_PORTS; i++) begin
         rsp_valid[i] = pop && (fifo_id_q[rd_ptr_q] == port_id_t'(i));
      end
   end

   always_comb begin
      ptr_d     = next_ptr;
      fifo_id_d = fifo_id_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
`ifdef TACHYON_MEM_ARB_ADDR_CHECK_EN
      fifo_addr_d = fifo_addr_q;
`endif
      if (push) begin
         fifo_id_d[wr_ptr_q] = gnt_id;
`ifdef TACHYON_MEM_ARB_ADDR_CHECK_EN
         fifo_addr_d[wr_ptr_q] = sel_addr;
`endif
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      if (spurious) begin
         err_d[ERR_SPURIOUS] = 1'b1;
      end
`ifdef TACHYON_MEM_ARB_ADDR_CHECK_EN
      if (pop && (ram_rd_addr_out != fifo_addr_q[rd_ptr_q])) begin
         err_d[ERR_ADDR_MISMATCH] = 1'b1;
      end
`else
      err_d[ERR_ADDR_MISMATCH] = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= '0;
         fifo_id_q <= '{default: '0};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         err_q     <= '0;
      end else begin
         ptr_q     <= ptr_d;
         fifo_id_q <= fifo_id_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

`ifdef TACHYON_MEM_ARB_ADDR_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_addr_q <= '{default: '0};
      end else begin
         fifo_addr_q <= fifo_addr_d;
      end
   end
`endif

   assign outstanding = cnt_q;
   assign err         = err_q;

endmodule

// File: tb/tb_tachyon_mem_arb.sv
// Randomized + directed bench for tachyon_mem_arb against a queue-based transaction model.
module tb_tachyon_mem_arb;

   localparam int unsigned NP   = 2;
   localparam int unsigned MAXO = 4;
   localparam int unsigned AW   = 30;
   localparam int unsigned DW   = 32;
   localparam int unsigned OW   = $clog2(MAXO) + 1;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NP-1:0]       req, wr_rd, gnt, rsp_valid;
   logic [NP*AW-1:0]    addr;
   logic [NP*DW-1:0]    wdata;
   logic [DW-1:0]       rsp_data, ram_wr_data, ram_rd_data;
   logic                ram_rd_en, ram_wr_en, ram_rd_valid;
   logic [AW-1:0]       ram_rd_addr, ram_wr_addr, ram_rd_addr_out;
   logic [OW-1:0]       outstanding;
   logic [1:0]          err;

   always #5 clk = ~clk;

   tachyon_mem_arb #(
      .NR_PORTS        (NP),
      .ADDR_WIDTH      (AW + 2),
      .DATA_WIDTH      (DW),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req             (req),
      .wr_rd           (wr_rd),
      .addr            (addr),
      .wdata           (wdata),
      .gnt             (gnt),
      .rsp_valid       (rsp_valid),
      .rsp_data        (rsp_data),
      .ram_rd_en       (ram_rd_en),
      .ram_rd_addr     (ram_rd_addr),
      .ram_wr_en       (ram_wr_en),
      .ram_wr_addr     (ram_wr_addr),
      .ram_wr_data     (ram_wr_data),
      .ram_rd_valid    (ram_rd_valid),
      .ram_rd_data     (ram_rd_data),
      .ram_rd_addr_out (ram_rd_addr_out),
      .outstanding     (outstanding),
      .err             (err)
   );

   typedef struct { int port; logic [AW-1:0] addr; } trk_t;
   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } rret_t;

   trk_t             trk[$];
   rret_t            ramq[$];
   logic [DW-1:0]    mem [logic [AW-1:0]];
   int               ptr;
   logic [1:0]       err_m;

   logic [NP-1:0]    p_req, p_wr;
   logic [AW-1:0]    p_addr [NP];
   logic [DW-1:0]    p_data [NP];
   bit               ret_en, spur_en, bad_addr;

   logic [NP-1:0]    s_gnt, s_rsp_valid;
   logic [DW-1:0]    s_rsp_data;

   int               n_tests, n_fail;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] data_for(input logic [AW-1:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'hC0DE_0000 ^ 32'(a);
   endfunction

   task automatic apply();
      req   = p_req;
      wr_rd = p_wr;
      for (int i = 0; i < NP; i++) begin
         addr[i*AW +: AW]  = p_addr[i];
         wdata[i*DW +: DW] = p_data[i];
      end
      ram_rd_valid = (ret_en && ramq.size() > 0) || spur_en;
      if (ramq.size() > 0) begin
         ram_rd_data     = ramq[0].data;
         ram_rd_addr_out = ramq[0].addr ^ (bad_addr ? 30'h4 : 30'h0);
      end else begin
         ram_rd_data     = $urandom;
         ram_rd_addr_out = '0;
      end
   endtask

   // One clock: drive at negedge, check just after, advance the model at posedge.
   task automatic cycle();
      int            e_id;
      bit            e_pop, e_spur, rd_ok;
      logic [NP-1:0] e_gnt, e_rv;
      logic          e_rd, e_wr;
      logic [AW-1:0] e_ra, e_wa;
      logic [DW-1:0] e_wd, e_rdata;
      trk_t          h;
      apply();
      e_id = -1; e_pop = 0; e_spur = 0;
      if (rst_n) begin
         rd_ok = (trk.size() < MAXO) || ram_rd_valid;
         for (int k = 0; k < NP; k++) begin
            int i;
            i = (ptr + k) % NP;
            if (e_id < 0 && p_req[i] && (p_wr[i] || rd_ok)) e_id = i;
         end
         e_pop  = ram_rd_valid && trk.size() > 0;
         e_spur = ram_rd_valid && trk.size() == 0;
      end
      e_gnt = '0; e_rd = 0; e_wr = 0; e_ra = '0; e_wa = '0; e_wd = '0;
      if (e_id >= 0) begin
         e_gnt[e_id] = 1'b1;
         if (p_wr[e_id]) begin
            e_wr = 1; e_wa = p_addr[e_id]; e_wd = p_data[e_id];
         end else begin
            e_rd = 1; e_ra = p_addr[e_id];
         end
      end
      e_rv = '0; e_rdata = '0;
      if (e_pop) begin
         e_rv[trk[0].port] = 1'b1;
         e_rdata = ram_rd_data;
      end
      #1;
      check("gnt", gnt, e_gnt);
      check("ram_rd_en", ram_rd_en, e_rd);
      check("ram_rd_addr", ram_rd_addr, e_ra);
      check("ram_wr_en", ram_wr_en, e_wr);
      check("ram_wr_addr", ram_wr_addr, e_wa);
      check("ram_wr_data", ram_wr_data, e_wd);
      check("rsp_valid", rsp_valid, e_rv);
      check("rsp_data", rsp_data, e_rdata);
      check("outstanding", outstanding, 64'(trk.size()));
      check("err", err, err_m);
      s_gnt = gnt; s_rsp_valid = rsp_valid; s_rsp_data = rsp_data;
      @(posedge clk);
      if (ram_rd_valid && ramq.size() > 0) void'(ramq.pop_front());
      if (e_pop) begin
         h = trk.pop_front();
`ifdef TACHYON_MEM_ARB_ADDR_CHECK_EN
         if (h.addr != ram_rd_addr_out) err_m[1] = 1'b1;
`endif
      end
      if (e_spur) err_m[0] = 1'b1;
      if (e_id >= 0) begin
         if (p_wr[e_id]) begin
            mem[p_addr[e_id]] = p_data[e_id];
         end else begin
            trk.push_back('{e_id, p_addr[e_id]});
            ramq.push_back('{p_addr[e_id], data_for(p_addr[e_id])});
         end
         ptr = (e_id + 1) % NP;
         p_req[e_id] = 1'b0;
      end
      @(negedge clk);
   endtask

   // Requests and a RAM return are held active during reset; all must be ignored.
   task automatic do_reset(input bit keep_ram, input int n);
      rst_n = 1'b0;
      ptr = 0; trk.delete(); err_m = '0;
      if (!keep_ram) ramq.delete();
      p_req = '1; p_wr = '0;
      ret_en = 0; spur_en = !keep_ram; bad_addr = 0;
      repeat (n) cycle();
      rst_n = 1'b1; spur_en = 0; p_req = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int gcount, n0, n1;
      n_tests = 0; n_fail = 0;
      p_req = '0; p_wr = '0;
      for (int i = 0; i < NP; i++) begin p_addr[i] = '0; p_data[i] = '0; end
      ret_en = 0; spur_en = 0; bad_addr = 0;
      apply();
      @(negedge clk);

      do_reset(0, 2);

      // Continuous reads from both ports: alternating grants, responses in grant order.
      ret_en = 1; p_addr[0] = 30'h1; p_addr[1] = 30'h2;
      for (int c = 0; c < 8; c++) begin
         p_req = '1; p_wr = '0;
         cycle();
         check("alt_gnt", s_gnt, (c % 2 == 0) ? 2'b01 : 2'b10);
         check("alt_rsp", s_rsp_valid, (c == 0) ? 2'b00 : (((c - 1) % 2 == 0) ? 2'b01 : 2'b10));
      end
      p_req = '0; repeat (2) cycle();

      // Write then read back through the RAM model.
      do_reset(0, 1);
      p_req = 2'b10; p_wr = 2'b10; p_addr[1] = 30'h10; p_data[1] = 32'hDEADBEEF;
      cycle(); check("wr_gnt", s_gnt, 2'b10);
      p_req = 2'b01; p_wr = 2'b00; p_addr[0] = 30'h10;
      cycle(); check("rd_gnt", s_gnt, 2'b01);
      ret_en = 1; cycle(); ret_en = 0;
      check("rb_valid", s_rsp_valid, 2'b01);
      check("rb_data", s_rsp_data, 32'hDEADBEEF);

      // Outstanding limit with the RAM stalled, then grant on a same-cycle return.
      do_reset(0, 1);
      ret_en = 0; n0 = 3; n1 = 3; gcount = 0;
      for (int c = 0; c < 8; c++) begin
         if (!p_req[0] && n0 > 0) begin p_req[0] = 1; p_wr[0] = 0; p_addr[0] = 30'h40 + 30'(n0); n0--; end
         if (!p_req[1] && n1 > 0) begin p_req[1] = 1; p_wr[1] = 0; p_addr[1] = 30'h80 + 30'(n1); n1--; end
         cycle();
         gcount += $countones(s_gnt);
      end
      check("lim_grants", gcount, 4);
      check("lim_outstanding", outstanding, 4);
      ret_en = 1; cycle();
      check("lim_gnt_on_ret", s_gnt, 2'b01);
      check("lim_out_hold", outstanding, 4);
      repeat (8) cycle();
      p_req = '0; ret_en = 0;

      // Spurious return.
      do_reset(0, 1);
      spur_en = 1; cycle(); spur_en = 0;
      check("spur_rsp", s_rsp_valid, 2'b00);
      check("spur_err", err, 2'b01);

      // Return address mismatch.
      do_reset(0, 1);
      p_req = 2'b01; p_wr = 2'b00; p_addr[0] = 30'h20;
      cycle();
      ret_en = 1; bad_addr = 1; cycle(); ret_en = 0; bad_addr = 0;
      check("amis_rsp", s_rsp_valid, 2'b01);
`ifdef TACHYON_MEM_ARB_ADDR_CHECK_EN
      check("amis_err1", err[1], 1'b1);
`else
      check("amis_err1", err[1], 1'b0);
`endif

      // Reset with reads in flight: later returns are spurious.
      do_reset(0, 1);
      ret_en = 0;
      for (int c = 0; c < 3; c++) begin p_req = 2'b11; p_wr = 2'b00; cycle(); end
      p_req = '0;
      check("rst_inflight", outstanding, 3);
      do_reset(1, 1);
      ret_en = 1;
      for (int c = 0; c < 3; c++) begin cycle(); check("rst_no_rsp", s_rsp_valid, 2'b00); end
      ret_en = 0;
      check("rst_outstanding", outstanding, 0);
      check("rst_err0", err[0], 1'b1);
      p_req = 2'b11; p_wr = 2'b00; cycle();
      check("rst_ptr0", s_gnt, 2'b01);
      p_req = '0; ret_en = 1; repeat (3) cycle(); ret_en = 0;

      // Random traffic.
      do_reset(0, 1);
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NP; i++) begin
            if (!p_req[i] && $urandom_range(0, 99) < 60) begin
               p_req[i]  = 1'b1;
               p_wr[i]   = ($urandom_range(0, 2) == 0);
               p_addr[i] = 30'($urandom_range(0, 15));
               p_data[i] = $urandom;
            end
         end
         ret_en = ($urandom_range(0, 99) < 40);
         cycle();
      end
      p_req = '0; ret_en = 1; repeat (6) cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tachyon_mem_arb.md
TACHYON_MEM_ARB -- requirements
Module: tachyon_mem_arb

Interface
REQ-001 SHALL have parameter NR_PORTS, default 2: number of requesting masters (cores, debug), range 1..8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: byte address width; word address is [ADDR_WIDTH-1:2].
REQ-003 SHALL have parameter DATA_WIDTH, default 32: RAM word width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4: in-flight read limit, power of two, at least 2.
REQ-005 SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock.
- rst_n  in  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low).
- req  in  NR_PORTS  per-port request, held until granted.
- wr_rd  in  NR_PORTS  per-port direction: 1=write, 0=read.
- addr  in  NR_PORTS*(ADDR_WIDTH-2)  per-port word address.
- wdata  in  NR_PORTS*DATA_WIDTH  per-port write data.
- gnt  out  NR_PORTS  one-hot grant, same cycle as accepted req.
- rsp_valid  out  NR_PORTS  one-hot read-data strobe.
- rsp_data  out  DATA_WIDTH  read data, shared by all ports.
- ram_rd_en, ram_rd_addr  out  1, ADDR_WIDTH-2  RAM read command.
- ram_wr_en, ram_wr_addr, ram_wr_data  out  1, ADDR_WIDTH-2, DATA_WIDTH  RAM write command.
- ram_rd_valid, ram_rd_data, ram_rd_addr_out  in  1, DATA_WIDTH, ADDR_WIDTH-2  RAM read return.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  reads in flight.
- err  out  2  sticky: [0]=spurious return, [1]=address mismatch.

Function
REQ-006 SHALL grant at most one port per cycle, round-robin: first requesting port at or after pointer ptr; on grant, ptr <= granted+1, wrapping NR_PORTS-1 to 0.
REQ-007 SHALL drive RAM command outputs combinationally from the granted port; ram_rd_en and ram_wr_en are never both 1.
REQ-008 SHALL grant writes unconditionally; a write produces no response.
REQ-009 SHALL grant a read only when outstanding<MAX_OUTSTANDING or ram_rd_valid=1 in the same cycle; otherwise that port is skipped and ptr does not advance past it.
REQ-010 SHALL push {port id, word addr} of each granted read into an in-order tracking FIFO.
REQ-011 SHALL, on ram_rd_valid with FIFO non-empty, pop the head and assert rsp_valid[head port] for exactly that cycle, with rsp_data=ram_rd_data (zero added latency).
REQ-012 SHALL, on ram_rd_valid with FIFO empty, drop the data, assert no rsp_valid, and set err[0].
REQ-013 SHALL handle push and pop in the same cycle with outstanding unchanged, including when full.
REQ-014 SHALL, when no port is granted, hold ram_* outputs at 0.

Reset
REQ-015 SHALL asynchronously on rst_n=0 clear ptr to 0, empty the FIFO, clear outstanding and err, and force gnt, rsp_valid, rsp_data to 0.
REQ-016 SHALL, after reset mid-operation, treat returns of pre-reset reads as spurious per REQ-012.

Configuration
REQ-017 SHALL, with TACHYON_MEM_ARB_ADDR_CHECK_EN defined, compare ram_rd_addr_out to the popped address and set err[1] on mismatch, still delivering the data.
REQ-018 SHALL, without TACHYON_MEM_ARB_ADDR_CHECK_EN, not store addresses in the FIFO and tie err[1] to 0.

Structure
REQ-019 SHALL take port-id typedef, err bit indices and MAX_PORTS=8 from shared package tachyon_pkg.
REQ-020 SHALL instantiate one sub-module, tachyon_rr_arbiter (request vector, pointer -> one-hot grant, next pointer).

Verification
REQ-021 NR_PORTS=2, both ports read continuously from reset -> grants alternate 0,1,0,1; rsp_valid order matches grant order.
REQ-022 Port 1 writes 0xDEADBEEF to word 0x10, then port 0 reads 0x10 -> rsp_valid[0] with rsp_data=0xDEADBEEF; rsp_valid[1] never set.
REQ-023 MAX_OUTSTANDING=4, RAM return stalled, 6 reads requested -> exactly 4 grants, outstanding=4; first return in same cycle as read request -> grant issued, outstanding stays 4.
REQ-024 ram_rd_valid pulsed with nothing in flight -> err=2'b01, no rsp_valid.
REQ-025 With TACHYON_MEM_ARB_ADDR_CHECK_EN, read 0x20, return ram_rd_addr_out=0x24 -> err[1]=1, data delivered; without the macro err[1]=0.
REQ-026 rst_n low with 3 reads in flight, then release, then 3 returns -> outstanding=0, ptr=0, err[0]=1, no rsp_valid.
